// File: rtl/a5_keystream_ctrl_if.sv
// Keystream stream handshake plus the control/observe lines of the three A5/1 shift registers.
interface a5_keystream_ctrl_if;
    logic       ks_valid;
    logic       ks_ready;
    logic       ks_bit;
    logic       lfsr_load;
    logic [2:0] lfsr_clk_en;
    logic       lfsr_d;
    logic [2:0] lfsr_q;
    logic [2:0] lfsr_clk_bit;

    modport master (
        output ks_valid, ks_bit, lfsr_load, lfsr_clk_en, lfsr_d,
        input  ks_ready, lfsr_q, lfsr_clk_bit
    );

    modport slave (
        input  ks_valid, ks_bit, lfsr_load, lfsr_clk_en, lfsr_d,
        output ks_ready, lfsr_q, lfsr_clk_bit
    );
endinterface

// File: rtl/a5_keystream_ctrl.sv
// A5/1 session sequencer: clear, key load, frame load, majority mixing, then
// streams the keystream over valid/ready while driving the external R1/R2/R3.
module a5_keystream_ctrl #(
    parameter int unsigned KEY_BITS   = 64,
    parameter int unsigned FRAME_BITS = 22,
    parameter int unsigned MIX_CYCLES = 100,
    parameter int unsigned KS_BITS    = 228
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    a5_keystream_ctrl_if.master   ks
);

    localparam int unsigned CNT_MAX0 = (KS_BITS > MIX_CYCLES) ? KS_BITS : MIX_CYCLES;
    localparam int unsigned CNT_MAX1 = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > CNT_MAX1) ? CNT_MAX0 : CNT_MAX1;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned KEY_IW   = $clog2(KEY_BITS);
    localparam int unsigned FRAME_IW = $clog2(FRAME_BITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_KEY   = 3'd2;
    localparam logic [2:0] S_FRAME = 3'd3;
    localparam logic [2:0] S_MIX   = 3'd4;
    localparam logic [2:0] S_PREP  = 3'd5;
    localparam logic [2:0] S_KS    = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  done_q, done_d;

    logic       load_c;
    logic [2:0] en_c;
    logic       d_c;
    logic       valid_c;
    logic       maj_c;
    logic [2:0] maj_en_c;

    // Registers whose clocking bit agrees with the majority step; always two or three.
    assign maj_c    = (ks.lfsr_clk_bit[0] & ks.lfsr_clk_bit[1]) |
                      (ks.lfsr_clk_bit[0] & ks.lfsr_clk_bit[2]) |
                      (ks.lfsr_clk_bit[1] & ks.lfsr_clk_bit[2]);
    assign maj_en_c = maj_c ? ks.lfsr_clk_bit : ~ks.lfsr_clk_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        en_c    = 3'b000;
        d_c     = 1'b0;
        valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    frame_d = frame;
                    state_d = S_CLR;
                    cnt_d   = '0;
                end
            end
            S_CLR: begin
                load_c  = 1'b1;
                state_d = S_KEY;
                cnt_d   = '0;
            end
            S_KEY: begin
                en_c = 3'b111;
                d_c  = key_q[cnt_q[KEY_IW-1:0]];
                if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
                    state_d = S_FRAME;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FRAME: begin
                en_c = 3'b111;
                d_c  = frame_q[cnt_q[FRAME_IW-1:0]];
                if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                    state_d = S_MIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MIX: begin
                en_c = maj_en_c;
                if (cnt_q == CNT_W'(MIX_CYCLES - 1)) begin
                    state_d = S_PREP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PREP: begin
                en_c    = maj_en_c;
                state_d = S_KS;
                cnt_d   = '0;
            end
            S_KS: begin
                valid_c = 1'b1;
                if (ks.ks_ready) begin
                    if (cnt_q == CNT_W'(KS_BITS - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        en_c  = maj_en_c;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort outranks start and handshakes; it also wipes the registers on the way out.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            load_c  = 1'b1;
            en_c    = 3'b000;
            d_c     = 1'b0;
            done_d  = 1'b0;
        end else if (abort) begin
            state_d = S_IDLE;
            key_d   = key_q;
            frame_d = frame_q;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign ks.ks_valid    = valid_c;
    assign ks.ks_bit      = ^ks.lfsr_q;
    assign ks.lfsr_load   = load_c;
    assign ks.lfsr_clk_en = en_c;
    assign ks.lfsr_d      = d_c;

endmodule
